// File: rtl/chain_fill_pkg.sv
// Shared types and defaults for the chamber-chain fill sequencer.
// The optional REPORT timeout is enabled with the CHAIN_FILL_TIMEOUT_EN macro.
package chain_fill_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRIME  = 3'd1,
    S_PUMP   = 3'd2,
    S_SETTLE = 3'd3,
    S_REPORT = 3'd4,
    S_ERR    = 3'd5
  } fill_state_e;

  localparam int DEF_N_CHAMBERS     = 32;
  localparam int DEF_PUMP_CYCLES    = 8;
  localparam int DEF_SETTLE_CYCLES  = 4;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  // Bits needed to address n values, never less than one.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/duty_counter.sv
// Loadable down-counter shared by the PUMP, SETTLE and REPORT-timeout phases.
module duty_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/chain_fill_sequencer.sv
// Drives inlet valve and pump one chamber volume at a time, then reports each filled
// chamber index over valid/ready. Define CHAIN_FILL_TIMEOUT_EN to enable the REPORT timeout.
module chain_fill_sequencer
  import chain_fill_pkg::*;
#(
  parameter int N_CHAMBERS     = DEF_N_CHAMBERS,
  parameter int PUMP_CYCLES    = DEF_PUMP_CYCLES,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int IDX_W          = idx_width(N_CHAMBERS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             fill_ready,
  output logic             inlet_valve,
  output logic             pump_en,
  output logic             fill_valid,
  output logic [IDX_W-1:0] fill_idx,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       state_dbg
);

  // Handshake: fill_valid/fill_idx hold steady while fill_valid=1; a report is
  // accepted on a rising edge where fill_valid=1, fill_ready=1 and abort=0.

  localparam int CNT_W = idx_width(max3(PUMP_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES) + 1);

  fill_state_e      state, next_state;
  logic [IDX_W-1:0] idx;
  logic             idx_clr, idx_inc, done_nxt;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             last_idx;

  assign last_idx  = (idx == IDX_W'(N_CHAMBERS - 1));
  assign fill_idx  = idx;
  assign state_dbg = state;

  duty_counter #(.W(CNT_W)) u_duty (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    next_state = state;
    idx_clr    = 1'b0;
    idx_inc    = 1'b0;
    done_nxt   = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_val    = '0;
    case (state)
      S_IDLE, S_ERR: begin
        if (start) begin
          next_state = S_PRIME;
          idx_clr    = 1'b1;
        end
      end
      S_PRIME: begin
        next_state = S_PUMP;
        cnt_load   = 1'b1;
        cnt_val    = CNT_W'(PUMP_CYCLES - 1);
      end
      S_PUMP: begin
        if (cnt_zero) begin
          next_state = S_SETTLE;
          cnt_load   = 1'b1;
          cnt_val    = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt_zero) begin
          next_state = S_REPORT;
          cnt_load   = 1'b1;
          cnt_val    = CNT_W'(TIMEOUT_CYCLES - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_REPORT: begin
        if (fill_ready) begin
          if (last_idx) begin
            next_state = S_IDLE;
            done_nxt   = 1'b1;
          end else begin
            next_state = S_PRIME;
            idx_inc    = 1'b1;
          end
        end else begin
`ifdef CHAIN_FILL_TIMEOUT_EN
          if (cnt_zero) begin
            next_state = S_ERR;
          end else begin
            cnt_dec = 1'b1;
          end
`endif
        end
      end
      default: next_state = S_IDLE;
    endcase
    // Abort outranks start and fill_ready: the report in flight is not accepted.
    if (abort) begin
      next_state = S_IDLE;
      idx_clr    = 1'b0;
      idx_inc    = 1'b0;
      done_nxt   = 1'b0;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      inlet_valve <= 1'b0;
      pump_en     <= 1'b0;
      fill_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state <= next_state;
      if (idx_clr) begin
        idx <= '0;
      end else if (idx_inc) begin
        idx <= idx + IDX_W'(1);
      end
      inlet_valve <= (next_state == S_PRIME) || (next_state == S_PUMP);
      pump_en     <= (next_state == S_PUMP);
      fill_valid  <= (next_state == S_REPORT);
      busy        <= (next_state != S_IDLE) && (next_state != S_ERR);
      done        <= done_nxt;
      err         <= (next_state == S_ERR);
    end
  end

endmodule

// File: tb/tb_chain_fill_sequencer.sv
// Self-checking bench for chain_fill_sequencer: vector table, directed sequences and a
// randomized run against a chamber/phase-arithmetic reference model.
module tb_chain_fill_sequencer;

  localparam int N = 4;
  localparam int P = 8;
  localparam int S = 4;
  localparam int T = 16;
  localparam int IW = 2;

  localparam logic [5:0] O_ZERO   = 6'b000000;
  localparam logic [5:0] O_PRIME  = 6'b100100;
  localparam logic [5:0] O_PUMP   = 6'b110100;
  localparam logic [5:0] O_SETTLE = 6'b000100;
  localparam logic [5:0] O_REPORT = 6'b001100;

  logic          clk = 1'b0;
  logic          rst, start, abort, fill_ready;
  logic          inlet_valve, pump_en, fill_valid, busy, done, err;
  logic [IW-1:0] fill_idx;
  logic [2:0]    state_dbg;
  logic [5:0]    outs;

  int n_checks = 0;
  int n_fail   = 0;

  logic [IW-1:0] exp_q[$];

  typedef struct {
    logic       rst;
    logic       start;
    logic       abort;
    logic       ready;
    int         n;
    logic [5:0] exp;
    int         idx;
  } vec_t;

  vec_t vecs[$];

  // Reference model: run flag, chamber number and cycle offset inside the chamber.
  bit m_active, m_err, m_done;
  int m_ch, m_t, m_wait;

  chain_fill_sequencer #(
    .N_CHAMBERS     (N),
    .PUMP_CYCLES    (P),
    .SETTLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .fill_ready  (fill_ready),
    .inlet_valve (inlet_valve),
    .pump_en     (pump_en),
    .fill_valid  (fill_valid),
    .fill_idx    (fill_idx),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  assign outs = {inlet_valve, pump_en, fill_valid, busy, done, err};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic a, input logic rd);
    rst        = r;
    start      = s;
    abort      = a;
    fill_ready = rd;
  endtask

  task automatic check_outs(input string name, input logic [5:0] exp);
    n_checks++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL %s: outs(valve,pump,valid,busy,done,err)=%b required %b at %0t", name, outs, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit a, input bit rd);
    m_done = 0;
    if (r) begin
      m_active = 0; m_err = 0; m_ch = 0; m_t = 0; m_wait = 0;
    end else if (a) begin
      m_active = 0; m_err = 0;
    end else if (!m_active) begin
      if (s) begin
        m_active = 1; m_err = 0; m_ch = 0; m_t = 0; m_wait = 0;
      end
    end else if (m_t > P + S) begin
      if (rd) begin
        if (m_ch == N - 1) begin
          m_active = 0; m_done = 1;
        end else begin
          m_ch++; m_t = 0; m_wait = 0;
        end
      end else begin
`ifdef CHAIN_FILL_TIMEOUT_EN
        m_wait++;
        if (m_wait == T) begin
          m_active = 0; m_err = 1;
        end
`endif
      end
    end else begin
      m_t++;
    end
  endtask

  function automatic logic [5:0] model_outs();
    logic v, p, fv;
    v  = m_active && (m_t <= P);
    p  = m_active && (m_t >= 1) && (m_t <= P);
    fv = m_active && (m_t > P + S);
    return {v, p, fv, logic'(m_active), logic'(m_done), logic'(m_err)};
  endfunction

  initial begin
    int pump_run, primes, dones, k, vcnt;
    logic [5:0] exp_o;
    bit r, s, a, rd;

    drive(1, 0, 0, 0);

    vecs.push_back('{1, 0, 0, 0, 2,  O_ZERO,   -1});
    vecs.push_back('{0, 0, 0, 0, 10, O_ZERO,   -1});
    vecs.push_back('{0, 1, 0, 1, 1,  O_PRIME,  -1});
    vecs.push_back('{0, 0, 0, 1, 8,  O_PUMP,   -1});
    vecs.push_back('{0, 0, 0, 1, 4,  O_SETTLE, -1});
    vecs.push_back('{0, 0, 0, 0, 3,  O_REPORT,  0});
    vecs.push_back('{0, 0, 0, 1, 1,  O_PRIME,  -1});
    vecs.push_back('{0, 0, 0, 0, 8,  O_PUMP,   -1});
    vecs.push_back('{0, 0, 0, 0, 4,  O_SETTLE, -1});
    vecs.push_back('{0, 0, 0, 0, 20, O_REPORT,  1});
    vecs.push_back('{0, 0, 0, 1, 1,  O_PRIME,  -1});
    vecs.push_back('{0, 1, 0, 0, 3,  O_PUMP,   -1});
    vecs.push_back('{0, 0, 1, 0, 1,  O_ZERO,   -1});
    vecs.push_back('{0, 0, 0, 0, 3,  O_ZERO,   -1});
    vecs.push_back('{0, 1, 0, 0, 1,  O_PRIME,  -1});
    vecs.push_back('{0, 0, 0, 0, 8,  O_PUMP,   -1});
    vecs.push_back('{0, 0, 0, 0, 4,  O_SETTLE, -1});
    vecs.push_back('{0, 0, 0, 0, 1,  O_REPORT,  0});
    vecs.push_back('{0, 0, 1, 1, 1,  O_ZERO,   -1});
    vecs.push_back('{0, 0, 0, 1, 2,  O_ZERO,   -1});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].abort, vecs[i].ready);
      for (int c = 0; c < vecs[i].n; c++) begin
        step();
        check_outs($sformatf("vec%0d.c%0d", i, c), vecs[i].exp);
        if (vecs[i].idx >= 0) check_int($sformatf("vec%0d.c%0d.idx", i, c), int'(fill_idx), vecs[i].idx);
      end
    end

    // Full run with fill_ready tied high.
    for (int i = 0; i < N; i++) exp_q.push_back(IW'(i));
    pump_run = 0; primes = 0; dones = 0;
    drive(0, 1, 0, 1);
    for (int c = 0; c < 80; c++) begin
      step();
      start = 0;
      if (inlet_valve && !pump_en) primes++;
      if (pump_en) pump_run++;
      else if (pump_run != 0) begin
        check_int("full.pump_len", pump_run, P);
        pump_run = 0;
      end
      if (fill_valid) begin
        if (exp_q.size() == 0) check_int("full.extra_report", 1, 0);
        else check_int("full.idx", int'(fill_idx), int'(exp_q.pop_front()));
      end
      if (done) begin
        dones++;
        check_int("full.busy_at_done", int'(busy), 0);
      end
    end
    check_int("full.done_count", dones, 1);
    check_int("full.prime_count", primes, N);
    check_int("full.reports_left", exp_q.size(), 0);
    check_outs("full.idle_after", O_ZERO);

`ifdef CHAIN_FILL_TIMEOUT_EN
    drive(0, 1, 0, 0);
    step();
    start = 0;
    for (k = 0; k < 40; k++) begin
      step();
      if (fill_valid) break;
    end
    check_int("tmo.reached_report", int'(fill_valid), 1);
    vcnt = 1;
    for (k = 0; k < 40; k++) begin
      step();
      if (!fill_valid) break;
      vcnt++;
    end
    check_int("tmo.report_cycles", vcnt, T);
    check_outs("tmo.err_state", 6'b000001);
    start = 1;
    step();
    start = 0;
    check_outs("tmo.restart_prime", O_PRIME);
    for (k = 0; k < 40; k++) begin
      step();
      if (fill_valid) break;
    end
    check_int("tmo.restart_idx", int'(fill_idx), 0);
    abort = 1;
    step();
    abort = 0;
    check_outs("tmo.abort_idle", O_ZERO);
`endif

    // Randomized run against the reference model.
    drive(1, 0, 0, 0);
    model_step(1, 0, 0, 0);
    step();
    check_outs("rand.reset", model_outs());
    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 499) == 0);
      s  = ($urandom_range(0, 7) == 0);
      a  = ($urandom_range(0, 59) == 0);
      rd = ($urandom_range(0, 99) < 35);
      drive(r, s, a, rd);
      model_step(r, s, a, rd);
      step();
      exp_o = model_outs();
      check_outs($sformatf("rand.c%0d", c), exp_o);
      if (exp_o[3]) check_int($sformatf("rand.c%0d.idx", c), int'(fill_idx), m_ch);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
